// File: rtl/vga_output_stage.sv
// vga_output_stage: 640x480@60 raster generator with pixel-state palette lookup.
// Sync, DataEnable and RGB leave one output register, delay-matched to the game core's latency.
module vga_output_stage #(
    parameter int H_DISPLAY     = 640,
    parameter int H_FRONT       = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BACK        = 48,
    parameter int V_DISPLAY     = 480,
    parameter int V_FRONT       = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BACK        = 33,
    parameter int CLK_DIV       = 2,
    parameter int STATE_LATENCY = 1
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [2:0] i_PixelState,
    output logic       o_PixEn,
    output logic [9:0] o_PixelX,
    output logic [9:0] o_PixelY,
    output logic       o_HSync,
    output logic       o_VSync,
    output logic       o_DataEnable,
    output logic [3:0] o_Red,
    output logic [3:0] o_Green,
    output logic [3:0] o_Blue,
    output logic       o_FrameTick
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_DISPLAY);
    localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_ACT    = 10'(V_DISPLAY);
    localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);

    logic [1:0]               divCnt;
    logic                     pixEn;
    logic [9:0]               hCnt;
    logic [9:0]               vCnt;
    logic                     active;
    logic                     hsN;
    logic                     vsN;
    logic [STATE_LATENCY-1:0] activePipe;
    logic [STATE_LATENCY-1:0] hsPipe;
    logic [STATE_LATENCY-1:0] vsPipe;
    logic [11:0]              paletteRgb;

    // Gated by reset so the strobe is low while held in reset, even with CLK_DIV=1.
    assign pixEn = (divCnt == DIV_LAST) && !i_Rst;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            divCnt <= '0;
        end else if (divCnt == DIV_LAST) begin
            divCnt <= '0;
        end else begin
            divCnt <= divCnt + 2'd1;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            hCnt <= '0;
            vCnt <= '0;
        end else if (pixEn) begin
            if (hCnt == H_LAST) begin
                hCnt <= '0;
                vCnt <= (vCnt == V_LAST) ? 10'd0 : vCnt + 10'd1;
            end else begin
                hCnt <= hCnt + 10'd1;
            end
        end
    end

    always_comb begin
        active = (hCnt < H_ACT) && (vCnt < V_ACT);
        hsN    = !((hCnt >= HS_FIRST) && (hCnt <= HS_LAST));
        vsN    = !((vCnt >= VS_FIRST) && (vCnt <= VS_LAST));
    end

    // Flags travel alongside the coordinate so they meet the returned pixel state.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            activePipe <= '0;
            hsPipe     <= '1;
            vsPipe     <= '1;
        end else if (pixEn) begin
            activePipe[0] <= active;
            hsPipe[0]     <= hsN;
            vsPipe[0]     <= vsN;
            for (int i = 1; i < STATE_LATENCY; i++) begin
                activePipe[i] <= activePipe[i-1];
                hsPipe[i]     <= hsPipe[i-1];
                vsPipe[i]     <= vsPipe[i-1];
            end
        end
    end

    always_comb begin
        paletteRgb = 12'hF0F;
        case (i_PixelState)
            3'b000:  paletteRgb = 12'h000;
            3'b001:  paletteRgb = 12'hFFF;
            3'b010:  paletteRgb = 12'hFF0;
            3'b011:  paletteRgb = 12'hF00;
            3'b100:  paletteRgb = 12'h0AF;
            default: paletteRgb = 12'hF0F;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            o_HSync                   <= 1'b1;
            o_VSync                   <= 1'b1;
            o_DataEnable              <= 1'b0;
            {o_Red, o_Green, o_Blue}  <= 12'h000;
        end else if (pixEn) begin
            o_HSync      <= hsPipe[STATE_LATENCY-1];
            o_VSync      <= vsPipe[STATE_LATENCY-1];
            o_DataEnable <= activePipe[STATE_LATENCY-1];
            if (activePipe[STATE_LATENCY-1]) begin
                {o_Red, o_Green, o_Blue} <= paletteRgb;
            end else begin
                {o_Red, o_Green, o_Blue} <= 12'h000;
            end
        end
    end

    assign o_PixEn     = pixEn;
    assign o_PixelX    = hCnt;
    assign o_PixelY    = vCnt;
    assign o_FrameTick = pixEn && (hCnt == 10'd0) && (vCnt == V_ACT);

endmodule

// File: tb/tb_vga_output_stage.sv
// tb_vga_output_stage: directed checks of raster timing, palette, latency and frame tick.
// Full-size timing on a default instance; frame-level checks on shrunken rasters.
module tb_vga_output_stage;
    // Small raster: H 16+2+4+2=24, V 12+2+2+3=19, CLK_DIV=2 -> line 48 clk, frame 912 clk.
    localparam int S_FRAME = 912;

    typedef struct {
        logic [2:0]  code;
        logic [11:0] rgb;
    } palVec_t;

    palVec_t palTab[8];

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // default-parameter instance
    logic [2:0] stA = 3'b001;
    logic       pixEnA, hsA, vsA, deA, ftA;
    logic [9:0] xA, yA;
    logic [3:0] rA, gA, bA;

    vga_output_stage dutA (
        .i_Clk(clk), .i_Rst(rst), .i_PixelState(stA),
        .o_PixEn(pixEnA), .o_PixelX(xA), .o_PixelY(yA),
        .o_HSync(hsA), .o_VSync(vsA), .o_DataEnable(deA),
        .o_Red(rA), .o_Green(gA), .o_Blue(bA), .o_FrameTick(ftA)
    );

    // small raster, latency 1
    logic       s1UseModel = 1'b0;
    logic [2:0] s1Const = 3'b000;
    logic [2:0] hit1 = 3'b000;
    logic [2:0] stS1;
    logic       pixEnS1, hsS1, vsS1, deS1, ftS1;
    logic [9:0] xS1, yS1;
    logic [3:0] rS1, gS1, bS1;

    assign stS1 = s1UseModel ? (hit1[0] ? 3'b001 : 3'b000) : s1Const;
    always @(posedge clk) begin
        if (rst) hit1 <= 3'b000;
        else if (pixEnS1) hit1 <= {hit1[1:0], (xS1 == 10'd5 && yS1 == 10'd3)};
    end

    vga_output_stage #(
        .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
        .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .CLK_DIV(2), .STATE_LATENCY(1)
    ) dutS1 (
        .i_Clk(clk), .i_Rst(rst), .i_PixelState(stS1),
        .o_PixEn(pixEnS1), .o_PixelX(xS1), .o_PixelY(yS1),
        .o_HSync(hsS1), .o_VSync(vsS1), .o_DataEnable(deS1),
        .o_Red(rS1), .o_Green(gS1), .o_Blue(bS1), .o_FrameTick(ftS1)
    );

    // small raster, latency 3
    logic [2:0] hit3 = 3'b000;
    logic [2:0] stS3;
    logic       pixEnS3, hsS3, vsS3, deS3, ftS3;
    logic [9:0] xS3, yS3;
    logic [3:0] rS3, gS3, bS3;

    assign stS3 = hit3[2] ? 3'b001 : 3'b000;
    always @(posedge clk) begin
        if (rst) hit3 <= 3'b000;
        else if (pixEnS3) hit3 <= {hit3[1:0], (xS3 == 10'd5 && yS3 == 10'd3)};
    end

    vga_output_stage #(
        .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
        .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .CLK_DIV(2), .STATE_LATENCY(3)
    ) dutS3 (
        .i_Clk(clk), .i_Rst(rst), .i_PixelState(stS3),
        .o_PixEn(pixEnS3), .o_PixelX(xS3), .o_PixelY(yS3),
        .o_HSync(hsS3), .o_VSync(vsS3), .o_DataEnable(deS3),
        .o_Red(rS3), .o_Green(gS3), .o_Blue(bS3), .o_FrameTick(ftS3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    int   found, prevHs, prevVs, prevDe, prevFt, c0, line, fr;
    int   hsLow[3], deHigh[3], hsFall[3], deRiseIdx, deFallIdx, ftCntA, vsHighA;
    int   vsLow[2], deHi2[2], deRise2[2], ftCnt[2], vsFall2, ftIdx0, ftBad;
    int   palBad, palDe, palBlank;
    logic [11:0] palFirst;
    int   tStart1, tStart3, white1, white3, first1, first3, whiteNoDe1, whiteNoDe3, syncBad;
    int   ftFirst, ftY, ftEarly;

    initial begin
        palTab[0] = '{3'b000, 12'h000};
        palTab[1] = '{3'b001, 12'hFFF};
        palTab[2] = '{3'b010, 12'hFF0};
        palTab[3] = '{3'b011, 12'hF00};
        palTab[4] = '{3'b100, 12'h0AF};
        palTab[5] = '{3'b101, 12'hF0F};
        palTab[6] = '{3'b110, 12'hF0F};
        palTab[7] = '{3'b111, 12'hF0F};

        // ---- reset mid-line on the full-size raster ----
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        found = 0;
        for (int k = 0; k < 6000 && found == 0; k++) begin
            @(negedge clk);
            if (xA == 10'd300 && yA == 10'd1) found = 1;
        end
        check("reach_x300_y1", found, 1);
        check("pre_rst_de", deA, 1);
        check("pre_rst_rgb", {rA, gA, bA}, 12'hFFF);
        rst = 1'b1;
        @(negedge clk);
        check("rst_pixen", pixEnA, 0);
        check("rst_x", xA, 0);
        check("rst_y", yA, 0);
        check("rst_hsync", hsA, 1);
        check("rst_vsync", vsA, 1);
        check("rst_de", deA, 0);
        check("rst_rgb", {rA, gA, bA}, 12'h000);
        check("rst_ft", ftA, 0);
        repeat (2) begin
            @(negedge clk);
            check("rst_hold_pixen", pixEnA, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("first_tick_pixen", pixEnA, 1);
        check("first_tick_x", xA, 0);
        @(negedge clk);
        check("after_tick_x", xA, 1);
        check("after_tick_pixen", pixEnA, 0);

        // ---- horizontal timing over 3 lines ----
        found = 0;
        prevHs = hsA;
        for (int k = 0; k < 4000 && found == 0; k++) begin
            @(negedge clk);
            if (prevHs == 1 && hsA == 0) found = 1;
            prevHs = hsA;
        end
        check("hs_first_fall", found, 1);
        for (int i = 0; i < 3; i++) begin hsLow[i] = 0; deHigh[i] = 0; hsFall[i] = -1; end
        prevHs = 0; prevDe = deA; deRiseIdx = -1; deFallIdx = -1; ftCntA = 0; vsHighA = 0;
        for (int i = 0; i < 4800; i++) begin
            line = i / 1600;
            if (!hsA) hsLow[line]++;
            if (deA) deHigh[line]++;
            if (ftA) ftCntA++;
            if (vsA) vsHighA++;
            if (i > 0 && prevHs == 1 && hsA == 0) hsFall[line] = i;
            if (deRiseIdx < 0 && prevDe == 0 && deA) deRiseIdx = i;
            if (deFallIdx < 0 && prevDe == 1 && !deA) deFallIdx = i;
            prevHs = hsA;
            prevDe = deA;
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("hs_low_line%0d", i), hsLow[i], 192);
            check($sformatf("de_high_line%0d", i), deHigh[i], 1280);
        end
        check("hs_fall_1", hsFall[1], 1600);
        check("hs_fall_2", hsFall[2], 3200);
        check("de_rise_after_hs", deRiseIdx, 288);
        check("de_fall_after_hs", deFallIdx, 1568);
        check("no_ft_top_lines", ftCntA, 0);
        check("vs_high_top_lines", vsHighA, 4800);

        // ---- palette table on the small raster ----
        for (int p = 0; p < 8; p++) begin
            rst = 1'b1;
            s1UseModel = 1'b0;
            s1Const = palTab[p].code;
            repeat (2) @(negedge clk);
            rst = 1'b0;
            palBad = 0; palDe = 0; palBlank = 0; palFirst = 12'hxxx;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (deS1) begin
                    if (palDe == 0) palFirst = {rS1, gS1, bS1};
                    palDe++;
                    if ({rS1, gS1, bS1} !== palTab[p].rgb) palBad++;
                end else begin
                    palBlank++;
                    if ({rS1, gS1, bS1} !== 12'h000) palBad++;
                end
            end
            check($sformatf("pal_%03b_first", palTab[p].code), palFirst, palTab[p].rgb);
            check($sformatf("pal_%03b_bad", palTab[p].code), palBad, 0);
            check($sformatf("pal_%03b_blank_seen", palTab[p].code), (palBlank > 0), 1);
        end

        // ---- latency: single white pixel at (5,3), L=1 and L=3 ----
        rst = 1'b1;
        s1UseModel = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tStart1 = -1; tStart3 = -1; white1 = 0; white3 = 0; first1 = -1; first3 = -1;
        whiteNoDe1 = 0; whiteNoDe3 = 0; syncBad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (pixEnS1 && xS1 == 10'd5 && yS1 == 10'd3) tStart1 = cyc;
            if (pixEnS3 && xS3 == 10'd5 && yS3 == 10'd3) tStart3 = cyc;
            if ({rS1, gS1, bS1} == 12'hFFF) begin
                if (first1 < 0) first1 = cyc;
                white1++;
                if (!deS1) whiteNoDe1++;
                if (!hsS1 || !vsS1) syncBad++;
            end
            if ({rS3, gS3, bS3} == 12'hFFF) begin
                if (first3 < 0) first3 = cyc;
                white3++;
                if (!deS3) whiteNoDe3++;
                if (!hsS3 || !vsS3) syncBad++;
            end
        end
        check("lat1_white_clocks", white1, 2);
        check("lat1_white_start", first1 - tStart1, 3);
        check("lat3_white_clocks", white3, 2);
        check("lat3_white_start", first3 - tStart3, 7);
        check("white_without_de", whiteNoDe1 + whiteNoDe3, 0);
        check("white_sync_active", syncBad, 0);

        // ---- vertical timing and frame tick over 2 small frames ----
        found = 0;
        prevVs = vsS1;
        for (int k = 0; k < 2000 && found == 0; k++) begin
            @(negedge clk);
            if (prevVs == 1 && vsS1 == 0) found = 1;
            prevVs = vsS1;
        end
        check("vs_first_fall", found, 1);
        for (int i = 0; i < 2; i++) begin vsLow[i] = 0; deHi2[i] = 0; deRise2[i] = 0; ftCnt[i] = 0; end
        prevVs = 0; prevDe = deS1; prevFt = 0; vsFall2 = -1; ftIdx0 = -1; ftBad = 0;
        for (int i = 0; i < 2 * S_FRAME; i++) begin
            fr = i / S_FRAME;
            if (!vsS1) vsLow[fr]++;
            if (deS1) deHi2[fr]++;
            if (prevDe == 0 && deS1) deRise2[fr]++;
            if (i > 0 && prevVs == 1 && vsS1 == 0) vsFall2 = i;
            if (ftS1) begin
                ftCnt[fr]++;
                if (ftIdx0 < 0) ftIdx0 = i;
                if (!pixEnS1 || xS1 != 10'd0 || yS1 != 10'd12 || prevFt == 1) ftBad++;
            end
            prevVs = vsS1;
            prevDe = deS1;
            prevFt = ftS1;
            @(negedge clk);
        end
        for (int i = 0; i < 2; i++) begin
            check($sformatf("vs_low_frame%0d", i), vsLow[i], 96);
            check($sformatf("de_high_frame%0d", i), deHi2[i], 384);
            check($sformatf("de_lines_frame%0d", i), deRise2[i], 12);
            check($sformatf("ft_count_frame%0d", i), ftCnt[i], 1);
        end
        check("vs_fall_period", vsFall2, S_FRAME);
        check("ft_offset", ftIdx0, 813);
        check("ft_shape", ftBad, 0);

        // ---- reset on the last visible line delays the frame tick ----
        found = 0;
        for (int k = 0; k < 2000 && found == 0; k++) begin
            @(negedge clk);
            if (yS1 == 10'd11 && xS1 == 10'd8) found = 1;
        end
        check("reach_y11", found, 1);
        rst = 1'b1;
        ftEarly = 0;
        repeat (3) begin
            @(negedge clk);
            if (ftS1) ftEarly++;
        end
        rst = 1'b0;
        c0 = cyc;
        ftFirst = -1; ftY = -1;
        for (int k = 0; k < 1200 && ftFirst < 0; k++) begin
            @(negedge clk);
            if (ftS1) begin
                ftFirst = cyc - c0;
                ftY = yS1;
            end
        end
        check("ft_during_rst", ftEarly, 0);
        check("ft_after_rst_delay", ftFirst, 577);
        check("ft_after_rst_y", ftY, 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
